// File: rtl/memory_round_controller.sv
// Round sequencer for the Memory Matrix game: fetches a board, shows it, collects the
// player's toggled guess, compares on submit and keeps score and lives.
module memory_round_controller #(
    parameter int unsigned SHOW_CYCLES   = 25_000_000,
    parameter int unsigned RESULT_CYCLES = 12_500_000,
    parameter int unsigned MAX_LIVES     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] board_in,
    input  logic       board_ready,
    input  logic [2:0] tile_sel,
    input  logic       tile_press,
    input  logic       submit,
    output logic       new_board,
    output logic [7:0] led,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic       round_win,
    output logic       game_over
);

    localparam int unsigned TimerMax =
        (SHOW_CYCLES > RESULT_CYCLES) ? SHOW_CYCLES : RESULT_CYCLES;
    localparam int unsigned TimerW = $clog2(TimerMax + 1);
    localparam logic [TimerW-1:0] ShowLast   = TimerW'(SHOW_CYCLES - 1);
    localparam logic [TimerW-1:0] ResultLast = TimerW'(RESULT_CYCLES - 1);
    localparam logic [1:0]        LivesInit  = 2'(MAX_LIVES);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StShow,
        StInput,
        StCheck,
        StResult,
        StOver
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        target_q, target_d;
    logic [7:0]        guess_q, guess_d;
    logic [7:0]        score_q, score_d;
    logic [1:0]        lives_q, lives_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              res_ok_q, res_ok_d;
    logic              start_prev_q;
    logic              start_armed_q, start_armed_d;

    logic start_rise;
    logic board_ok;
    logic match;
    logic show_done;
    logic result_done;

    // A start key held through reset release must be seen low once before it can act.
    assign start_rise  = start & ~start_prev_q & start_armed_q;
    assign board_ok    = board_ready && (board_in != 8'h00);
    assign match       = (guess_q == target_q);
    assign show_done   = (timer_q == ShowLast);
    assign result_done = (timer_q == ResultLast);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start_rise) state_d = StReq;
            StReq:    if (board_ok) state_d = StShow;
            StShow:   if (show_done) state_d = StInput;
            StInput:  if (submit) state_d = StCheck;
            StCheck:  state_d = StResult;
            StResult: if (result_done) state_d = (lives_q == 2'd0) ? StOver : StReq;
            StOver:   if (start_rise) state_d = StReq;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        new_board = 1'b0;
        led       = 8'h00;
        round_win = 1'b0;
        game_over = 1'b0;
        unique case (state_q)
            StReq:    new_board = 1'b1;
            StShow:   led = target_q;
            StInput:  led = guess_q;
            StCheck: begin
                led       = guess_q;
                round_win = match;
            end
            StResult: led = res_ok_q ? 8'hFF : 8'h00;
            StOver: begin
                game_over = 1'b1;
                led       = score_q;
            end
            default: ;
        endcase
    end

    assign score = score_q;
    assign lives = lives_q;

    always_comb begin
        target_d      = target_q;
        guess_d       = guess_q;
        score_d       = score_q;
        lives_d       = lives_q;
        timer_d       = timer_q;
        res_ok_d      = res_ok_q;
        start_armed_d = start_armed_q | ~start;
        unique case (state_q)
            StIdle, StOver: begin
                if (start_rise) begin
                    score_d = 8'h00;
                    lives_d = LivesInit;
                end
            end
            StReq: begin
                if (board_ok) begin
                    target_d = board_in;
                    timer_d  = '0;
                end
            end
            StShow: begin
                timer_d = timer_q + TimerW'(1);
                if (show_done) guess_d = 8'h00;
            end
            StInput: begin
                if (tile_press) guess_d[tile_sel] = ~guess_q[tile_sel];
            end
            StCheck: begin
                res_ok_d = match;
                timer_d  = '0;
                if (match) begin
                    if (score_q != 8'hFF) score_d = score_q + 8'd1;
                end else if (lives_q != 2'd0) begin
                    lives_d = lives_q - 2'd1;
                end
            end
            StResult: timer_d = timer_q + TimerW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            target_q      <= 8'h00;
            guess_q       <= 8'h00;
            score_q       <= 8'h00;
            lives_q       <= 2'd0;
            timer_q       <= '0;
            res_ok_q      <= 1'b0;
            start_prev_q  <= 1'b0;
            start_armed_q <= 1'b0;
        end else begin
            target_q      <= target_d;
            guess_q       <= guess_d;
            score_q       <= score_d;
            lives_q       <= lives_d;
            timer_q       <= timer_d;
            res_ok_q      <= res_ok_d;
            start_prev_q  <= start;
            start_armed_q <= start_armed_d;
        end
    end

endmodule
